// File: rtl/dram_be_multiport_if.sv
// rtl/dram_be_multiport_if.sv - write/read bus bundle for the multi-port byte-enable RAM
interface dram_be_multiport_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_RD     = 2
);
    logic                         we;
    logic [DATA_WIDTH/8-1:0]      be;
    logic [ADDR_WIDTH-1:0]        waddr;
    logic [DATA_WIDTH-1:0]        di;
    logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
    logic [NUM_RD*DATA_WIDTH-1:0] dout;
    logic                         busy;
    logic                         wr_drop;

    modport master (
        output we, be, waddr, di, raddr,
        input  dout, busy, wr_drop
    );

    modport slave (
        input  we, be, waddr, di, raddr,
        output dout, busy, wr_drop
    );
endinterface

// File: rtl/dram_be_multiport.sv
// rtl/dram_be_multiport.sv - distributed RAM, async multi-port read, byte-enable write, clear sequencer
// Optional write-first forwarding from di to dout is enabled by defining DRAM_WR_BYPASS_EN.
module dram_be_multiport #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_DEPTH = 16,
    parameter int                    NUM_RD     = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_WORD  = '0
) (
    input  logic                 wclk,
    input  logic                 rst,
    dram_be_multiport_if.slave   bus
);
    localparam int                    NB      = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DATA_DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                          state, state_nxt;
    logic [ADDR_WIDTH-1:0]           clr_cnt, clr_cnt_nxt;
    logic                            wr_drop_q, drop_nxt;
    logic                            busy;
    logic                            w_in_range;
    logic                            clr_we;
    logic                            wr_en;
    logic [DATA_WIDTH-1:0]           mem [DATA_DEPTH];
    logic [NUM_RD*DATA_WIDTH-1:0]    dout_flat;
    logic [ADDR_WIDTH-1:0]           ra;
    logic [DATA_WIDTH-1:0]           word;

    assign w_in_range = {1'b0, bus.waddr} < DEPTH_X;
    assign clr_we     = (state == CLEAR) && !rst;
    assign wr_en      = (state == READY) && !rst && bus.we && w_in_range && (bus.be != '0);

    always_ff @(posedge wclk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            wr_drop_q <= drop_nxt;
        end
    end

    // Ending on a compare to LAST keeps a full-power-of-two depth from wrapping into a second pass.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        drop_nxt    = bus.we && ((state == CLEAR) || !w_in_range);
        if (state == CLEAR) begin
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == LAST) begin
                state_nxt = READY;
            end
        end
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    assign bus.busy    = busy;
    assign bus.wr_drop = wr_drop_q;

    // Array has no reset so it maps onto distributed RAM; the clear sequence defines contents.
    always_ff @(posedge wclk) begin
        if (clr_we) begin
            mem[clr_cnt] <= INIT_WORD;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.be[i]) begin
                    mem[bus.waddr][i*8 +: 8] <= bus.di[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        dout_flat = '0;
        ra        = '0;
        word      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra   = bus.raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            word = '0;
            if ((state == READY) && ({1'b0, ra} < DEPTH_X)) begin
                word = mem[ra];
`ifdef DRAM_WR_BYPASS_EN
                if (bus.we && w_in_range && (ra == bus.waddr)) begin
                    for (int i = 0; i < NB; i++) begin
                        if (bus.be[i]) begin
                            word[i*8 +: 8] = bus.di[i*8 +: 8];
                        end
                    end
                end
`else
`endif
            end
            dout_flat[k*DATA_WIDTH +: DATA_WIDTH] = word;
        end
    end

    assign bus.dout = dout_flat;
endmodule
